// File: rtl/traffic_phase_controller.sv
// Two-way intersection phase sequencer: alternates NS/EW green phases with an
// all-red clearance between them, drives the shared countdown and per-direction
// enables, and lets a pedestrian request shorten the current green.
module traffic_phase_controller #(
  parameter int unsigned CLK_DIV      = 1000,
  parameter int unsigned PHASE_TIME   = 120,
  parameter int unsigned ALL_RED_TIME = 2,
  parameter int unsigned PED_TIME     = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       ped_request,
  output logic [6:0] master_timer,
  output logic       ns_enable,
  output logic       ew_enable,
  output logic       phase_done
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CLR_W = $clog2(ALL_RED_TIME + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NS_GO  = 3'd1,
    CLR_NS = 3'd2,
    EW_GO  = 3'd3,
    CLR_EW = 3'd4
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  logic [CLR_W-1:0] clr_cnt;
  logic             ped_pending;
  logic             tick_c;
  logic             in_go_c;

  // One-second tick; the prescaler only runs outside IDLE.
  assign tick_c  = (state != IDLE) && (prescaler == PRE_W'(CLK_DIV - 1));
  assign in_go_c = (state == NS_GO) || (state == EW_GO);

  // Prescaler: held at 0 in IDLE (and on the way there), wraps at CLK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if ((state == IDLE) || !run || tick_c) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  // Pedestrian latch: consumed by an active green phase, otherwise sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pending <= 1'b0;
    end else if (in_go_c && run && ped_pending) begin
      ped_pending <= 1'b0;
    end else if (ped_request) begin
      ped_pending <= 1'b1;
    end
  end

  // Phase sequencer with registered timer, enables and phase_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      master_timer <= '0;
      ns_enable    <= 1'b0;
      ew_enable    <= 1'b0;
      phase_done   <= 1'b0;
      clr_cnt      <= '0;
    end else begin
      phase_done <= 1'b0;
      if (!run) begin
        state        <= IDLE;
        master_timer <= '0;
        ns_enable    <= 1'b0;
        ew_enable    <= 1'b0;
        clr_cnt      <= '0;
      end else begin
        case (state)
          IDLE: begin
            state        <= NS_GO;
            master_timer <= 7'(PHASE_TIME);
            ns_enable    <= 1'b1;
            ew_enable    <= 1'b0;
          end
          NS_GO, EW_GO: begin
            if (ped_pending && (master_timer > 7'(PED_TIME))) begin
              master_timer <= 7'(PED_TIME);
            end else if (tick_c) begin
              if (master_timer == 7'd0) begin
                state      <= (state == NS_GO) ? CLR_NS : CLR_EW;
                ns_enable  <= 1'b0;
                ew_enable  <= 1'b0;
                clr_cnt    <= CLR_W'(ALL_RED_TIME);
                phase_done <= 1'b1;
              end else begin
                master_timer <= master_timer - 7'd1;
              end
            end
          end
          CLR_NS, CLR_EW: begin
            master_timer <= '0;
            if (tick_c) begin
              if (clr_cnt == CLR_W'(1)) begin
                state        <= (state == CLR_NS) ? EW_GO : NS_GO;
                master_timer <= 7'(PHASE_TIME);
                ns_enable    <= (state == CLR_EW);
                ew_enable    <= (state == CLR_NS);
                clr_cnt      <= '0;
              end else begin
                clr_cnt <= clr_cnt - CLR_W'(1);
              end
            end
          end
          default: begin
            state        <= IDLE;
            master_timer <= '0;
            ns_enable    <= 1'b0;
            ew_enable    <= 1'b0;
            clr_cnt      <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Upstream sequencer for a two-way intersection.
- Generates the 7-bit `master_timer` countdown and the per-direction `enable` signals that drive two `traffic_light` instances: one north-south (NS) and one east-west (EW).
- Alternates right-of-way between NS and EW, with an all-red clearance interval between them.
- Supports a pedestrian request that shortens the current green.

Parameters:
- CLK_DIV, 1000: clock cycles per one-second tick; must be ≥ 2.
- PHASE_TIME, 120: `master_timer` load value at the start of each green phase; must be ≤ 127.
- ALL_RED_TIME, 2: ticks spent in all-red clearance; must be ≥ 1.
- PED_TIME, 30: value `master_timer` is cut to on a pedestrian request; must be > 15 and < PHASE_TIME.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level; high = sequence active, low = intersection held all-red.
- ped_request  input  1  level; sampled every cycle.
- master_timer  output  7  countdown shared by both lights.
- ns_enable  output  1  enable for the NS `traffic_light`.
- ew_enable  output  1  enable for the EW `traffic_light`.
- phase_done  output  1  one-cycle pulse when a green phase ends.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; prescaler = 0; clearance counter = 0; ped_pending = 0.
  - `master_timer` = 0, `ns_enable` = 0, `ew_enable` = 0, `phase_done` = 0.
  - Reset mid-phase aborts the phase with no `phase_done` pulse.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - `tick` is high for one cycle when count == CLK_DIV-1.
  - Held at 0 in IDLE, so the first tick of the first phase arrives CLK_DIV cycles after leaving IDLE.
- States: IDLE, NS_GO, CLR_NS, EW_GO, CLR_EW.
  - IDLE → NS_GO: when `run` is high. Next cycle: `master_timer` = PHASE_TIME, `ns_enable` = 1.
  - NS_GO / EW_GO:
    - On tick with `master_timer` > 0: decrement by 1.
    - On tick with `master_timer` == 0: go to CLR_NS / CLR_EW; that direction's enable = 0; clearance counter = ALL_RED_TIME; `phase_done` pulses in the same cycle.
    - A green phase therefore lasts PHASE_TIME+1 ticks, with `master_timer` showing PHASE_TIME..0 for one tick each.
  - CLR_NS / CLR_EW:
    - Both enables = 0; `master_timer` held at 0.
    - Clearance counter decrements on each tick.
    - On the tick where counter == 1: CLR_NS → EW_GO, CLR_EW → NS_GO; `master_timer` = PHASE_TIME; the new direction's enable = 1.
  - `run` low in any non-IDLE state:
    - Next cycle → IDLE; all outputs return to reset values.
    - A pending pedestrian request is retained.
    - `run` re-asserted always restarts at NS_GO.
- Pedestrian request:
  - `ped_pending` is set when `ped_request` = 1; it holds through CLR and IDLE states.
  - In a GO state with `ped_pending` = 1:
    - If `master_timer` > PED_TIME: next cycle `master_timer` = PED_TIME and `ped_pending` clears. This load overrides a coincident tick decrement.
    - If `master_timer` ≤ PED_TIME: `ped_pending` clears with no effect on the timer.
  - If `ped_request` is still high when pending clears, it re-sets on the next cycle.
- Invariants:
  - `ns_enable` and `ew_enable` are never high together.
  - `master_timer` never underflows below 0 and never exceeds PHASE_TIME.
  - All outputs are registered.

Test Plan (CLK_DIV=4, PHASE_TIME=20, ALL_RED_TIME=2, PED_TIME=18 unless stated):
1. Assert `rst` mid-cycle, then release; hold `run` = 0 for 50 cycles.
   - Required: all outputs are 0 immediately on `rst` and stay 0 while `run` = 0.
2. Raise `run`.
   - One cycle later: `ns_enable` = 1, `master_timer` = 20.
   - Timer reaches 0 after 80 cycles.
   - After 4 more cycles: `phase_done` pulses once and `ns_enable` falls.
   - After 8 more cycles: `ew_enable` = 1, `master_timer` = 20.
3. Run a full NS→EW→NS cycle.
   - Required: enables never overlap; each enable is high for 84 cycles; all-red gaps are 8 cycles.
4. Pulse `ped_request` for 1 cycle while NS `master_timer` = 19.
   - Required: next cycle `master_timer` = 18; the timer then continues down to 0 normally.
   - Repeat the pulse at `master_timer` = 10: the timer is unaffected.
5. Pulse `ped_request` during CLR_NS.
   - Required: EW phase loads 20, then within 1 cycle drops to 18.
6. Deassert `run` at NS `master_timer` = 7, re-assert 10 cycles later.
   - Required: IDLE outputs are all 0 with no `phase_done` pulse; the sequence restarts at NS_GO with `master_timer` = 20.
   - Assert `rst` during CLR_EW: all outputs are 0 immediately.
